multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview: Issue/writeback controller that sits directly upstream of the iterative multiplier and divider in the processor's execute stage. Latches the X-stage operands, pulses the unit's start strobe, and holds the operands stable for the whole iteration. Stalls the pipeline until the unit reports ready, then emits a single-cycle writeback to rd, or to $rstatus on exception.

Parameters:
WIDTH, 32, operand/result width
REG_ADDR_W, 5, register-file address width
RSTATUS_REG, 30, writeback register used on exception
MULT_EXC_CODE, 4, value written to RSTATUS_REG on multiply overflow
DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide exception
TIMEOUT, 40, watchdog limit in cycles (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  X stage holds a valid instruction
is_mult  in  1  instruction is mul
is_div  in  1  instruction is div
flush  in  1  abort the in-flight operation (branch/jump squash)
op_a  in  WIDTH  rs operand
op_b  in  WIDTH  rt operand
op_rd  in  REG_ADDR_W  destination register
md_operandA  out  WIDTH  held operand A to the unit
md_operandB  out  WIDTH  held operand B to the unit
ctrl_MULT  out  1  one-cycle multiply start
ctrl_DIV  out  1  one-cycle divide start
md_result  in  WIDTH  unit data_result
md_exception  in  1  unit data_exception
md_resultRDY  in  1  unit data_resultRDY
stall  out  1  freeze fetch/decode/X latches
wb_valid  out  1  one-cycle writeback strobe
wb_we  out  1  register write enable, qualifies wb_valid
wb_rd  out  REG_ADDR_W  writeback register
wb_data  out  WIDTH  writeback value
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, active high): FSM=IDLE. All outputs are 0, including the held operands, ctrl strobes, stall, wb_* and busy.
- FSM states: IDLE, START, BUSY, DONE.
- IDLE:
  - stall = issue_valid & (is_mult | is_div), combinational.
  - On that condition at a clock edge: latch op_a, op_b, op_rd and the op kind, then go to START.
  - is_mult has priority if both is_mult and is_div are set.
- START (exactly 1 cycle):
  - ctrl_MULT or ctrl_DIV = 1 according to the latched kind.
  - md_resultRDY is ignored in this cycle, because it is stale from the previous operation.
  - Next state is BUSY.
- BUSY:
  - Wait for md_resultRDY=1.
  - On the ready edge, capture md_result and md_exception, then go to DONE.
- DONE (1 cycle):
  - stall=0, wb_valid=1.
  - If the captured exception is 1: wb_rd=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE by kind, wb_we=1.
  - If it is 0: wb_rd=latched rd, wb_data=captured result, wb_we=(rd!=0).
  - Next state is IDLE. A new issue is accepted only from IDLE, so there is no back-to-back accept in DONE.
- stall=1 throughout START and BUSY.
- md_operandA and md_operandB stay constant from START through DONE, because the unit reads them every iteration.
- flush in START or BUSY: return to IDLE next edge, with no writeback and no strobe. flush in IDLE or DONE has no effect.
- Latency: for a multiply with 16-cycle readiness, accept edge → START → 16 BUSY cycles → DONE. stall is high for 18 cycles including the accept cycle.
- Reset mid-operation: immediate return to IDLE. Outputs drop asynchronously and no writeback occurs.

Optional Feature:
MULTDIV_WATCHDOG_EN:
- Defined: a cycle counter is cleared in START and increments in BUSY. If it reaches TIMEOUT without md_resultRDY, go to DONE with exception forced to 1, which writes the exception code to RSTATUS_REG.
- Undefined: no counter, and BUSY waits indefinitely.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams), op-kind encoding, and the RSTATUS_REG, MULT_EXC_CODE and DIV_EXC_CODE constants.
- One natural sub-module, multdiv_operand_latch: the enable-loaded operand/rd/kind holding register with async reset, built on the codebase's parameterised register.

Test Plan:
- mul 7×6, rd=3 → ctrl_MULT high for one cycle after accept; operands held; stall high 18 cycles; wb_valid with wb_rd=3, wb_data=42, wb_we=1.
- mul 0x40000000×4 with md_exception=1 → wb_rd=30, wb_data=4, wb_we=1.
- div 9÷0 with md_exception=1 → ctrl_DIV pulse; wb_rd=30, wb_data=5.
- mul to rd=0, no exception → wb_valid=1, wb_we=0.
- flush asserted on the 5th BUSY cycle → state IDLE next cycle, no wb_valid; a new mul issued afterwards completes normally.
- reset asserted mid-BUSY → all outputs 0 immediately, no writeback. With MULTDIV_WATCHDOG_EN and md_resultRDY held low → DONE after 40 BUSY cycles, wb_rd=30, wb_data=4.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl_pkg
// Purpose  : Shared encodings for the mul/div issue controller: FSM states,
//            operation kind and the exception writeback constants.
// Revision : 1.0 - initial release
// ============================================================================
package multdiv_issue_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_busy  = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = c_st_idle,
    ST_START = c_st_start,
    ST_BUSY  = c_st_busy,
    ST_DONE  = c_st_done
  } state_t;

  // Operation kind held for the duration of one operation
  typedef enum logic {
    KIND_MULT = 1'b0,
    KIND_DIV  = 1'b1
  } op_kind_t;

  // Exception writeback target and codes
  localparam int c_rstatus_reg   = 30;
  localparam int c_mult_exc_code = 4;
  localparam int c_div_exc_code  = 5;

  // Default watchdog limit in BUSY cycles
  localparam int c_timeout       = 40;

endpackage
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl_if
// Purpose  : Bundles the X-stage issue inputs, the mul/div unit handshake and
//            the writeback/stall outputs of the issue controller.
//            slave  = controller view, master = pipeline/unit view.
// Revision : 1.0 - initial release
// ============================================================================
interface multdiv_issue_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  // X-stage issue
  logic                  issue_valid;
  logic                  is_mult;
  logic                  is_div;
  logic                  flush;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [REG_ADDR_W-1:0] op_rd;
  // Unit side
  logic [WIDTH-1:0]      md_operandA;
  logic [WIDTH-1:0]      md_operandB;
  logic                  ctrl_MULT;
  logic                  ctrl_DIV;
  logic [WIDTH-1:0]      md_result;
  logic                  md_exception;
  logic                  md_resultRDY;
  // Pipeline control and writeback
  logic                  stall;
  logic                  wb_valid;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]      wb_data;
  logic                  busy;

  modport slave (
    input  issue_valid, is_mult, is_div, flush, op_a, op_b, op_rd,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
    output stall, wb_valid, wb_we, wb_rd, wb_data, busy
  );

  modport master (
    output issue_valid, is_mult, is_div, flush, op_a, op_b, op_rd,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
    input  stall, wb_valid, wb_we, wb_rd, wb_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/multdiv_operand_latch.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_operand_latch
// Purpose  : Enable-loaded holding register for operand A/B, destination
//            register and operation kind. Loaded once at issue and held
//            stable while the iterative unit re-reads the operands.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_operand_latch
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic                  load,
  input  wire logic [WIDTH-1:0]      op_a,
  input  wire logic [WIDTH-1:0]      op_b,
  input  wire logic [REG_ADDR_W-1:0] op_rd,
  input  wire op_kind_t              kind_d,
  output      logic [WIDTH-1:0]      op_a_q,
  output      logic [WIDTH-1:0]      op_b_q,
  output      logic [REG_ADDR_W-1:0] rd_q,
  output      op_kind_t              kind_q
);

  // Capture the issuing instruction's operands; hold otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a_q <= '0;
      op_b_q <= '0;
      rd_q   <= '0;
      kind_q <= KIND_MULT;
    end else if (load) begin
      op_a_q <= op_a;
      op_b_q <= op_b;
      rd_q   <= op_rd;
      kind_q <= kind_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue_ctrl
// Purpose  : Issue/writeback controller in front of the iterative mul/div
//            unit. Latches X-stage operands, pulses the start strobe, stalls
//            the pipeline until the unit is ready and emits one writeback
//            (to rd, or to $rstatus on exception).
// Options  : MULTDIV_WATCHDOG_EN - BUSY watchdog forcing an exception
//            writeback after TIMEOUT cycles without md_resultRDY.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int RSTATUS_REG   = c_rstatus_reg,
  parameter int MULT_EXC_CODE = c_mult_exc_code,
`ifdef MULTDIV_WATCHDOG_EN
  parameter int TIMEOUT       = c_timeout,
`endif
  parameter int DIV_EXC_CODE  = c_div_exc_code
) (
  input wire logic             clock,
  input wire logic             reset,
  multdiv_issue_ctrl_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  op_kind_t              w_kind_d;
  op_kind_t              w_kind_q;
  logic [WIDTH-1:0]      w_op_a_q;
  logic [WIDTH-1:0]      w_op_b_q;
  logic [REG_ADDR_W-1:0] w_rd_q;
  logic                  w_capture;
  logic                  w_exc_d;
  logic [WIDTH-1:0]      r_result;
  logic                  r_exc;

  // A mul/div in X is accepted only from IDLE; mul wins if both flags are set
  assign w_accept = (r_state == ST_IDLE) & bus.issue_valid & (bus.is_mult | bus.is_div);
  assign w_kind_d = bus.is_mult ? KIND_MULT : KIND_DIV;

  multdiv_operand_latch #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_operand_latch (
    .clock  (clock),
    .reset  (reset),
    .load   (w_accept),
    .op_a   (bus.op_a),
    .op_b   (bus.op_b),
    .op_rd  (bus.op_rd),
    .kind_d (w_kind_d),
    .op_a_q (w_op_a_q),
    .op_b_q (w_op_b_q),
    .rd_q   (w_rd_q),
    .kind_q (w_kind_q)
  );

  // Held operands drive the unit directly so they stay put for every iteration
  assign bus.md_operandA = w_op_a_q;
  assign bus.md_operandB = w_op_b_q;

`ifdef MULTDIV_WATCHDOG_EN
  localparam int c_wd_w = $clog2(TIMEOUT + 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              w_wd_expired;

  // Count BUSY cycles; START clears so each operation gets a full budget
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_wd_cnt <= '0;
    end else if ((r_state == ST_BUSY) && !w_wd_expired) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Last permitted BUSY cycle is the TIMEOUT-th one
  assign w_wd_expired = (r_wd_cnt == c_wd_w'(TIMEOUT - 1));
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the unit's result and exception on the ready (or timeout) edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_capture) begin
      r_result <= bus.md_result;
      r_exc    <= w_exc_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_exc_d       = bus.md_exception;
    bus.stall     = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_we     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.busy      = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        // Reset forces every output low, even with an issue pending
        bus.stall = w_accept & ~reset;
        if (w_accept) begin
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        // md_resultRDY still reflects the previous operation here; ignore it
        bus.stall     = 1'b1;
        bus.ctrl_MULT = ~bus.flush & (w_kind_q == KIND_MULT);
        bus.ctrl_DIV  = ~bus.flush & (w_kind_q == KIND_DIV);
        w_state_nxt   = bus.flush ? ST_IDLE : ST_BUSY;
      end

      ST_BUSY: begin
        bus.stall = 1'b1;
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.md_resultRDY) begin
          w_state_nxt = ST_DONE;
          w_capture   = 1'b1;
        end
`ifdef MULTDIV_WATCHDOG_EN
        else if (w_wd_expired) begin
          w_state_nxt = ST_DONE;
          w_capture   = 1'b1;
          w_exc_d     = 1'b1;
        end
`endif
      end

      ST_DONE: begin
        bus.wb_valid = 1'b1;
        if (r_exc) begin
          bus.wb_rd   = REG_ADDR_W'(RSTATUS_REG);
          bus.wb_we   = 1'b1;
          bus.wb_data = (w_kind_q == KIND_DIV) ? WIDTH'(DIV_EXC_CODE)
                                               : WIDTH'(MULT_EXC_CODE);
        end else begin
          bus.wb_rd   = w_rd_q;
          bus.wb_we   = |w_rd_q;
          bus.wb_data = r_result;
        end
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_issue_ctrl
// Purpose  : Directed self-checking bench for multdiv_issue_ctrl; the bench
//            plays both the X stage and the iterative unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  multdiv_issue_ctrl_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

  multdiv_issue_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.is_mult      = 1'b0;
    bus.is_div       = 1'b0;
    bus.flush        = 1'b0;
    bus.op_a         = '0;
    bus.op_b         = '0;
    bus.op_rd        = '0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
  endtask

  // Present an instruction for one cycle, end in START with a stale ready
  task automatic issue(input bit div, input bit both, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, output int stall_cnt);
    bus.issue_valid = 1'b1;
    bus.is_mult     = !div || both;
    bus.is_div      = div || both;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.op_rd       = rd;
    #1;
    stall_cnt = int'(bus.stall);
    tick();
    idle_inputs();
    bus.md_resultRDY = 1'b1;
    bus.md_result    = 32'hDEAD_BEEF;
    #1;
    stall_cnt += int'(bus.stall);
  endtask

  // Full operation: issue, BUSY for busy_cycles, then check the writeback
  task automatic run_op(input string tag, input bit div, input bit both,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int busy_cycles, input logic [31:0] res, input bit exc,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data, input bit exp_we);
    int stall_cnt;
    issue(div, both, a, b, rd, stall_cnt);
    check({tag, ".ctrl_MULT"}, bus.ctrl_MULT, (!div || both) ? 1 : 0);
    check({tag, ".ctrl_DIV"}, bus.ctrl_DIV, (div && !both) ? 1 : 0);
    check({tag, ".opA_start"}, bus.md_operandA, a);
    check({tag, ".opB_start"}, bus.md_operandB, b);
    for (int i = 1; i <= busy_cycles; i++) begin
      tick();
      bus.md_resultRDY = (i == busy_cycles);
      bus.md_result    = res;
      bus.md_exception = exc;
      #1;
      stall_cnt += int'(bus.stall);
      if (i == 1) begin
        check({tag, ".strobe_one_cycle"}, {bus.ctrl_MULT, bus.ctrl_DIV}, 0);
        check({tag, ".stale_rdy_ignored"}, {bus.busy, bus.wb_valid}, 2'b10);
      end
    end
    tick();
    idle_inputs();
    #1;
    check({tag, ".wb_valid"}, bus.wb_valid, 1);
    check({tag, ".wb_rd"}, bus.wb_rd, exp_rd);
    check({tag, ".wb_data"}, bus.wb_data, exp_data);
    check({tag, ".wb_we"}, bus.wb_we, exp_we);
    check({tag, ".stall_done"}, bus.stall, 0);
    check({tag, ".opA_done"}, bus.md_operandA, a);
    check({tag, ".stall_cycles"}, stall_cnt, busy_cycles + 2);
    tick();
    #1;
    check({tag, ".back_idle"}, {bus.busy, bus.wb_valid}, 0);
  endtask

  initial begin
    int stall_cnt;
    int seen_wb;
    int k;

    reset = 1'b1;
    idle_inputs();
    #12;
    check("reset.busy", bus.busy, 0);
    check("reset.stall", bus.stall, 0);
    check("reset.wb", {bus.wb_valid, bus.wb_we, bus.wb_rd}, 0);
    check("reset.wb_data", bus.wb_data, 0);
    check("reset.operands", bus.md_operandA | bus.md_operandB, 0);
    check("reset.strobes", {bus.ctrl_MULT, bus.ctrl_DIV}, 0);
    tick();
    reset = 1'b0;
    #1;

    // name, div, both, a, b, rd, busy, result, exc, exp_rd, exp_data, exp_we
    run_op("mul7x6",  1'b0, 1'b0, 32'd7, 32'd6, 5'd3, 16, 32'd42, 1'b0, 5'd3, 32'd42, 1'b1);
    run_op("mul_ovf", 1'b0, 1'b0, 32'h4000_0000, 32'd4, 5'd7, 16, 32'd0, 1'b1, 5'd30, 32'd4, 1'b1);
    run_op("div0",    1'b1, 1'b0, 32'd9, 32'd0, 5'd8, 32, 32'd0, 1'b1, 5'd30, 32'd5, 1'b1);
    run_op("mul_rd0", 1'b0, 1'b0, 32'd5, 32'd5, 5'd0, 3, 32'd25, 1'b0, 5'd0, 32'd25, 1'b0);
    run_op("div100",  1'b1, 1'b0, 32'd100, 32'd7, 5'd12, 5, 32'd14, 1'b0, 5'd12, 32'd14, 1'b1);
    run_op("both_mul", 1'b0, 1'b1, 32'd3, 32'd11, 5'd9, 2, 32'd33, 1'b1, 5'd30, 32'd4, 1'b1);

    // Flush on the 5th BUSY cycle
    issue(1'b0, 1'b0, 32'd2, 32'd3, 5'd4, stall_cnt);
    for (int i = 1; i <= 5; i++) begin
      tick();
      bus.md_resultRDY = 1'b0;
      bus.flush        = (i == 5);
      #1;
    end
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush.idle", {bus.busy, bus.stall, bus.wb_valid}, 0);
    tick();
    check("flush.no_wb", bus.wb_valid, 0);
    run_op("after_flush", 1'b0, 1'b0, 32'd2, 32'd3, 5'd4, 4, 32'd6, 1'b0, 5'd4, 32'd6, 1'b1);

    // Asynchronous reset in the middle of BUSY
    issue(1'b0, 1'b0, 32'd13, 32'd17, 5'd5, stall_cnt);
    for (int i = 1; i <= 3; i++) begin
      tick();
      bus.md_resultRDY = 1'b0;
      #1;
    end
    reset = 1'b1;
    #1;
    check("rst_mid.state", {bus.busy, bus.stall, bus.wb_valid}, 0);
    check("rst_mid.operands", bus.md_operandA | bus.md_operandB, 0);
    bus.issue_valid  = 1'b1;
    bus.is_mult      = 1'b1;
    bus.md_resultRDY = 1'b1;
    #1;
    check("rst_mid.stall_gated", bus.stall, 0);
    tick();
    reset = 1'b0;
    idle_inputs();
    seen_wb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_wb += int'(bus.wb_valid) + int'(bus.busy);
    end
    check("rst_mid.no_wb", seen_wb, 0);

    // Unit never reports ready
    issue(1'b0, 1'b0, 32'd1, 32'd1, 5'd6, stall_cnt);
    bus.md_resultRDY = 1'b0;
`ifdef MULTDIV_WATCHDOG_EN
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.wb_valid) begin
        k = i;
        break;
      end
    end
    check("wd.busy_cycles", k - 1, 40);
    check("wd.wb_rd", bus.wb_rd, 30);
    check("wd.wb_data", bus.wb_data, 4);
    check("wd.wb_we", bus.wb_we, 1);
    tick();
    check("wd.back_idle", bus.busy, 0);
`else
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      k += int'(bus.wb_valid);
    end
    check("nowd.no_wb", k, 0);
    check("nowd.still_busy", {bus.busy, bus.stall}, 2'b11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("nowd.flushed", bus.busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
